// File: rtl/multiplicador_seq_param.sv
// Shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH product, one product bit per clock.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH (busy WIDTH cycles).
// Backpressure: none; start ignored while busy, accepted in IDLE or DONE (back-to-back capable).
// Option MULT_SIGNED_EN: per-operation two's-complement mode selected by is_signed at accept.
module multiplicador_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     S_result,
  output logic                 ov
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               ov_q, ov_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] result;
  logic               result_ov;
  logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic sgn_q, sgn_d;
`else
  // Mode input has no effect in the unsigned-only build.
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
`endif

  // Operand conditioning: in signed mode the core only ever sees magnitudes.
  always_comb begin
    a_mag = A;
    b_mag = B;
`ifdef MULT_SIGNED_EN
    if (is_signed && A[WIDTH-1]) a_mag = '0 - A;
    if (is_signed && B[WIDTH-1]) b_mag = '0 - B;
`endif
  end

  // One shift-add step plus the final result/overflow as seen on DONE entry.
  always_comb begin
    sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    acc_step  = {sum, acc_q[WIDTH-1:1]};
    result    = acc_step;
    result_ov = |acc_step[2*WIDTH-1:WIDTH];
`ifdef MULT_SIGNED_EN
    if (neg_q) result = '0 - acc_step;
    // Signed fit: upper half plus the WIDTH-1 sign bit must all match.
    if (sgn_q) result_ov = !((&result[2*WIDTH-1:WIDTH-1]) || !(|result[2*WIDTH-1:WIDTH-1]));
`endif
  end

  // Next-state for the FSM and datapath registers.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ov_d      = ov_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
    sgn_d     = sgn_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          cnt_d   = '0;
`ifdef MULT_SIGNED_EN
          sgn_d   = is_signed;
          neg_d   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
`endif
        end
      end
      RUN: begin
        acc_d = acc_step;
        if (cnt_q == LAST_CNT) begin
          // Last bit consumed: publish the product, counter parks at zero.
          state_d   = DONE;
          cnt_d     = '0;
          product_d = result;
          ov_d      = result_ov;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ov_q      <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ov_q      <= ov_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
      sgn_q     <= sgn_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign product  = product_q;
  assign S_result = product_q[WIDTH-1:0];
  assign ov       = ov_q;

endmodule

// File: tb/tb_multiplicador_seq_param.sv
// Directed bench for multiplicador_seq_param: WIDTH=8 instance plus a WIDTH=16 instance.
module tb_multiplicador_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_signed;
  logic [7:0]  a, b;
  logic        busy, done, ov;
  logic [15:0] product;
  logic [7:0]  s_result;

  logic        start16, is_signed16;
  logic [15:0] a16, b16;
  logic        busy16, done16, ov16;
  logic [31:0] product16;
  logic [15:0] s_result16;

  int checks   = 0;
  int failures = 0;
  int n;
  int dc;

  always #5 clk = ~clk;

  multiplicador_seq_param #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .A(a), .B(b), .busy(busy), .done(done),
    .product(product), .S_result(s_result), .ov(ov)
  );

  multiplicador_seq_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .is_signed(is_signed16),
    .A(a16), .B(b16), .busy(busy16), .done(done16),
    .product(product16), .S_result(s_result16), .ov(ov16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single operation on the 8-bit unit; entered and left 1ns after a rising edge, unit idle.
  task automatic op8(input string tag, input logic [7:0] opa, input logic [7:0] opb,
                     input logic sg, input logic [15:0] exp_p, input logic exp_ov);
    int cyc;
    int bc;
    a = opa; b = opb; is_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bc = 0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"},  64'(cyc), 64'd8);
    chk({tag, "_busy"}, 64'(bc), 64'd8);
    chk({tag, "_prod"}, 64'(product), 64'(exp_p));
    chk({tag, "_s"},    64'(s_result), 64'(exp_p[7:0]));
    chk({tag, "_ov"},   64'(ov), 64'(exp_ov));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"},  64'(product), 64'(exp_p));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start16 = 1'b0; is_signed16 = 1'b0; a16 = '0; b16 = '0;

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", 64'(product), 64'd0);
    chk("rst_s",    64'(s_result), 64'd0);
    chk("rst_ov",   64'(ov), 64'd0);
    chk("rst_prod16", 64'(product16), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic unsigned products and boundaries
    op8("t1",  8'd13,  8'd11,  1'b0, 16'h008F, 1'b0);
    op8("t2a", 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
    op8("t2b", 8'd0,   8'd200, 1'b0, 16'h0000, 1'b0);
    op8("t2c", 8'd128, 8'd2,   1'b0, 16'h0100, 1'b1);
    op8("t2d", 8'd255, 8'd1,   1'b0, 16'h00FF, 1'b0);

    // Back-to-back with a stray start during RUN
    a = 8'd5; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 3) begin
        a = 8'd9; b = 8'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("t3_lat1",  64'(n), 64'd8);
    chk("t3_prod1", 64'(product), 64'd25);
    a = 8'd2; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t3_nogap_busy", 64'(busy), 64'd1);
    chk("t3_nogap_done", 64'(done), 64'd0);
    chk("t3_run_hold",   64'(product), 64'd25);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t3_lat2",  64'(n), 64'd8);
    chk("t3_prod2", 64'(product), 64'd6);
    @(posedge clk); #1;
    chk("t3_pulse", 64'(done), 64'd0);

    // Reset in the middle of RUN
    op8("t4pre", 8'd200, 8'd200, 1'b0, 16'h9C40, 1'b1);
    a = 8'd100; b = 8'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t4_inrun", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_prod", 64'(product), 64'd0);
    chk("t4_s",    64'(s_result), 64'd0);
    chk("t4_ov",   64'(ov), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dc = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    chk("t4_nodone", 64'(dc), 64'd0);
    chk("t4_idle",   64'(busy), 64'd0);
    op8("t4", 8'd7, 8'd9, 1'b0, 16'd63, 1'b0);

    // Signed mode (or its absence)
`ifdef MULT_SIGNED_EN
    op8("t5a", 8'hFD, 8'd5,  1'b1, 16'hFFF1, 1'b0);
    op8("t5b", 8'h80, 8'hFF, 1'b1, 16'h0080, 1'b1);
    op8("t5c", 8'h80, 8'd1,  1'b1, 16'hFF80, 1'b0);
    op8("t5d", 8'hFD, 8'd5,  1'b0, 16'h04F1, 1'b1);
`else
    op8("t5u", 8'hFD, 8'd5,  1'b1, 16'h04F1, 1'b1);
`endif

    // 16-bit instance
    a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_lat",  64'(n), 64'd16);
    chk("t6_prod", 64'(product16), 64'h0001_FFFE);
    chk("t6_s",    64'(s_result16), 64'hFFFE);
    chk("t6_ov",   64'(ov16), 64'd1);
    @(posedge clk); #1;
    chk("t6_pulse", 64'(done16), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
